// File: rtl/switch_alloc_rr_np.sv
// Round-robin switch allocator with a registered output stage: NUM_PORTS inputs x NUM_PORTS outputs.
// Optional build macro SA_GRANT_CNT_EN adds saturating per-output grant counters (grant_cnt, cnt_clr).
module switch_alloc_rr_np #(
  parameter int DATASIZE    = 40,
  parameter int NUM_PORTS   = 5,
  parameter int PW          = $clog2(NUM_PORTS),
  parameter bit ALLOW_UTURN = 1'b0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_PORTS-1:0]          in_valid,
  input  logic [NUM_PORTS*PW-1:0]       in_label,
  input  logic [NUM_PORTS*DATASIZE-1:0] in_data,
  output logic [NUM_PORTS-1:0]          in_ready,
  input  logic [NUM_PORTS-1:0]          out_full,
  output logic [NUM_PORTS-1:0]          out_winc,
  output logic [NUM_PORTS*DATASIZE-1:0] out_data,
  output logic [NUM_PORTS*NUM_PORTS-1:0] out_grant,
  output logic                          bad_label
`ifdef SA_GRANT_CNT_EN
  ,
  input  logic                          cnt_clr,
  output logic [NUM_PORTS*16-1:0]       grant_cnt
`endif
);

  logic [PW-1:0]        label     [NUM_PORTS];
  logic [NUM_PORTS-1:0] legal;
  logic [NUM_PORTS-1:0] req       [NUM_PORTS];
  logic [NUM_PORTS-1:0] grant     [NUM_PORTS];
  logic [NUM_PORTS-1:0] has_grant;
  logic [PW-1:0]        win       [NUM_PORTS];
  logic [PW-1:0]        ptr       [NUM_PORTS];

  // NOTE: every signal written in an always_comb gets a default first, so no path infers a latch.
  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      label[i] = in_label[i*PW +: PW];
      legal[i] = (int'(label[i]) < NUM_PORTS) &&
                 (ALLOW_UTURN || (i == 0) || (int'(label[i]) != i));
    end
    for (int o = 0; o < NUM_PORTS; o++) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        req[o][i] = in_valid[i] && legal[i] && (int'(label[i]) == o);
      end
    end
  end

  // Per-output search starting at ptr[o], wrapping back to input 0.
  always_comb begin
    int idx;
    idx = 0;
    for (int o = 0; o < NUM_PORTS; o++) begin
      grant[o]     = '0;
      win[o]       = '0;
      has_grant[o] = 1'b0;
      for (int k = 0; k < NUM_PORTS; k++) begin
        idx = int'(ptr[o]) + k;
        if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
        if (!out_full[o] && !has_grant[o] && req[o][idx]) begin
          grant[o][idx] = 1'b1;
          win[o]        = PW'(idx);
          has_grant[o]  = 1'b1;
        end
      end
    end
  end

  always_comb begin
    in_ready = '0;
    for (int o = 0; o < NUM_PORTS; o++) begin
      in_ready = in_ready | grant[o];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_winc  <= '0;
      out_data  <= '0;
      out_grant <= '0;
      bad_label <= 1'b0;
      for (int o = 0; o < NUM_PORTS; o++) ptr[o] <= '0;
    end else begin
      bad_label <= bad_label | (|(in_valid & ~legal));
      for (int o = 0; o < NUM_PORTS; o++) begin
        out_winc[o] <= has_grant[o];
        if (has_grant[o]) begin
          out_data[o*DATASIZE +: DATASIZE]    <= in_data[int'(win[o])*DATASIZE +: DATASIZE];
          out_grant[o*NUM_PORTS +: NUM_PORTS] <= grant[o];
          ptr[o] <= (int'(win[o]) == NUM_PORTS - 1) ? '0 : win[o] + 1'b1;
        end
      end
    end
  end

`ifdef SA_GRANT_CNT_EN
  logic [15:0] cnt [NUM_PORTS];

  // Counts registered writes; clear takes priority over a same-cycle increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int o = 0; o < NUM_PORTS; o++) cnt[o] <= '0;
    end else begin
      for (int o = 0; o < NUM_PORTS; o++) begin
        if (cnt_clr) cnt[o] <= '0;
        else if (out_winc[o] && (cnt[o] != 16'hFFFF)) cnt[o] <= cnt[o] + 16'd1;
      end
    end
  end

  always_comb begin
    grant_cnt = '0;
    for (int o = 0; o < NUM_PORTS; o++) grant_cnt[o*16 +: 16] = cnt[o];
  end
`endif

endmodule

// File: tb/tb_switch_alloc_rr_np.sv
// Scoreboard bench for switch_alloc_rr_np (NUM_PORTS=5, DATASIZE=40, ALLOW_UTURN=0).
// Expected outputs are computed from a behavioural model when stimulus is driven, then popped one cycle later.
module tb_switch_alloc_rr_np;
  localparam int N  = 5;
  localparam int D  = 40;
  localparam int PW = 3;

  typedef struct {
    logic [N-1:0]   winc;
    logic [N*D-1:0] data;
    logic [N*N-1:0] grant;
    logic           bad;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   in_valid;
  logic [N*PW-1:0] in_label;
  logic [N*D-1:0] in_data;
  logic [N-1:0]   in_ready;
  logic [N-1:0]   out_full;
  logic [N-1:0]   out_winc;
  logic [N*D-1:0] out_data;
  logic [N*N-1:0] out_grant;
  logic           bad_label;
`ifdef SA_GRANT_CNT_EN
  logic           cnt_clr;
  logic [N*16-1:0] grant_cnt;
`endif

  int checks = 0;
  int errors = 0;

  exp_t sb[$];
  int             m_ptr [N];
  logic [N*D-1:0] m_data;
  logic [N*N-1:0] m_grant;
  logic           m_bad;

  switch_alloc_rr_np #(.DATASIZE(D), .NUM_PORTS(N), .ALLOW_UTURN(1'b0)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_label(in_label), .in_data(in_data), .in_ready(in_ready),
    .out_full(out_full), .out_winc(out_winc), .out_data(out_data), .out_grant(out_grant),
    .bad_label(bad_label)
`ifdef SA_GRANT_CNT_EN
    , .cnt_clr(cnt_clr), .grant_cnt(grant_cnt)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int o = 0; o < N; o++) m_ptr[o] = 0;
    m_data  = '0;
    m_grant = '0;
    m_bad   = 1'b0;
    sb.delete();
  endtask

  task automatic clr_in();
    in_valid = '0;
    in_label = '0;
    in_data  = '0;
    out_full = '0;
  endtask

  task automatic set_in(input int i, input logic [PW-1:0] lbl, input logic [D-1:0] d);
    in_valid[i]          = 1'b1;
    in_label[i*PW +: PW] = lbl;
    in_data[i*D +: D]    = d;
  endtask

  // Behavioural reference: legality, round-robin winner per output, pointer advance, sticky error.
  task automatic model_cycle(output logic [N-1:0] rdy, output exp_t e);
    int lbl [N];
    bit ok  [N];
    rdy = '0;
    e.winc = '0;
    for (int i = 0; i < N; i++) begin
      lbl[i] = int'(in_label[i*PW +: PW]);
      ok[i]  = (lbl[i] < N) && (i == 0 || lbl[i] != i);
      if (in_valid[i] && !ok[i]) m_bad = 1'b1;
    end
    for (int o = 0; o < N; o++) begin
      if (!out_full[o]) begin
        for (int k = 0; k < N; k++) begin
          int i;
          i = (m_ptr[o] + k) % N;
          if (!e.winc[o] && in_valid[i] && ok[i] && lbl[i] == o) begin
            e.winc[o] = 1'b1;
            rdy[i]    = 1'b1;
            m_data[o*D +: D]  = in_data[i*D +: D];
            m_grant[o*N +: N] = N'(1) << i;
            m_ptr[o] = (i + 1) % N;
          end
        end
      end
    end
    e.data  = m_data;
    e.grant = m_grant;
    e.bad   = m_bad;
  endtask

  // Called just after a rising edge with inputs already driven.
  task automatic step(input string tag);
    logic [N-1:0] rdy;
    exp_t e;
    exp_t got;
    model_cycle(rdy, e);
    #3;
    check({tag, ".in_ready"}, 256'(in_ready), 256'(rdy));
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    check({tag, ".out_winc"},  256'(out_winc),  256'(got.winc));
    check({tag, ".out_data"},  256'(out_data),  256'(got.data));
    check({tag, ".out_grant"}, 256'(out_grant), 256'(got.grant));
    check({tag, ".bad_label"}, 256'(bad_label), 256'(got.bad));
  endtask

  initial begin
    rst_n = 1'b0;
    clr_in();
`ifdef SA_GRANT_CNT_EN
    cnt_clr = 1'b0;
`endif
    model_reset();
    #12;
    check("rst.out_winc",  256'(out_winc),  256'(0));
    check("rst.out_data",  256'(out_data),  256'(0));
    check("rst.out_grant", 256'(out_grant), 256'(0));
    check("rst.bad_label", 256'(bad_label), 256'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Single flit: input 1 to output 3.
    clr_in();
    set_in(1, 3'd3, 40'hA5);
    step("single");
    clr_in();
    step("idle");

    // Contention: inputs 0, 2, 4 all target output 1.
    for (int c = 0; c < 6; c++) begin
      clr_in();
      set_in(0, 3'd1, 40'h10 + 40'(c));
      set_in(2, 3'd1, 40'h20 + 40'(c));
      set_in(4, 3'd1, 40'h40 + 40'(c));
      step("contend");
    end

    // Back-pressure on output 2, then release.
    for (int c = 0; c < 4; c++) begin
      clr_in();
      set_in(3, 3'd2, 40'hBEEF_0003);
      out_full[2] = (c < 3);
      step("bp");
    end

    // Illegal labels: U-turn on input 2, then out-of-range on input 1.
    clr_in();
    set_in(2, 3'd2, 40'h22);
    step("uturn");
    clr_in();
    set_in(1, 3'd7, 40'h77);
    step("range");
    clr_in();
    step("sticky");

    // Parallel: all inputs to distinct outputs, with input 0 using Local.
    clr_in();
    set_in(0, 3'd0, 40'hC0);
    set_in(1, 3'd2, 40'hC1);
    set_in(2, 3'd3, 40'hC2);
    set_in(3, 3'd4, 40'hC3);
    set_in(4, 3'd1, 40'hC4);
    step("parallel");

    // Reset asserted mid-cycle: registered outputs clear immediately.
    #3;
    rst_n = 1'b0;
    #1;
    check("midrst.out_winc",  256'(out_winc),  256'(0));
    check("midrst.out_data",  256'(out_data),  256'(0));
    check("midrst.out_grant", 256'(out_grant), 256'(0));
    check("midrst.bad_label", 256'(bad_label), 256'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();

    // Pointers restart at 0 after reset.
    for (int c = 0; c < 3; c++) begin
      clr_in();
      set_in(2, 3'd1, 40'h200 + 40'(c));
      set_in(4, 3'd1, 40'h400 + 40'(c));
      step("postrst");
    end
    clr_in();
    step("drain");

`ifdef SA_GRANT_CNT_EN
    clr_in();
    set_in(0, 3'd0, 40'h1);
    repeat (70000) @(posedge clk);
    #1;
    check("cnt.sat", 256'(grant_cnt[15:0]), 256'(16'hFFFF));
    cnt_clr = 1'b1;
    @(posedge clk);
    #1;
    cnt_clr = 1'b0;
    check("cnt.clr", 256'(grant_cnt[15:0]), 256'(0));
    clr_in();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
